// File: rtl/cudu_dispatch.sv
// Operand dispatcher: buffers x/y pairs in a FIFO and issues them one at a time to the cudu engine.
// Define CUDU_DISPATCH_CNT_EN to build the jobs_done completed-job counter; otherwise jobs_done is 0.
module cudu_dispatch #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [3:0] in_x,
  input  logic [3:0] in_y,
  output logic       in_ready,
  output logic       eng_start,
  output logic [3:0] eng_xin,
  output logic [3:0] eng_yin,
  input  logic       eng_idle,
  input  logic       eng_done,
  input  logic [7:0] eng_x,
  output logic       res_valid,
  output logic [7:0] res_data,
  input  logic       res_ready,
  output logic [7:0] jobs_done
);

  // Producer side: a push completes on any edge with in_valid && in_ready.
  // Consumer side: the result is taken on any edge with res_valid && res_ready.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;

  logic [7:0] mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [7:0] head;
  logic       full;
  logic       empty;
  logic       push;
  logic       pop;
  logic       capture;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign head     = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= {in_x, in_y};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (!empty && !res_valid && eng_idle) begin
          state_nxt = START;
        end
      end
      START: begin
        if (!eng_idle) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (eng_done) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode; eng_start comes straight from the state flop so reset drops it at once.
  always_comb begin
    eng_start = 1'b0;
    pop       = 1'b0;
    capture   = 1'b0;
    unique case (state)
      IDLE:    pop       = !empty && !res_valid && eng_idle;
      START:   eng_start = 1'b1;
      WAIT:    capture   = eng_done;
      default: ;
    endcase
  end

  // Operands are loaded only on a pop, so they hold steady for the whole job.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      eng_xin <= '0;
      eng_yin <= '0;
    end else if (pop) begin
      eng_xin <= head[7:4];
      eng_yin <= head[3:0];
    end
  end

  // No pop happens while res_valid is set, so a capture never lands on an unread result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_valid <= 1'b0;
      res_data  <= '0;
    end else if (capture) begin
      res_valid <= 1'b1;
      res_data  <= eng_x;
    end else if (res_valid && res_ready) begin
      res_valid <= 1'b0;
    end
  end

`ifdef CUDU_DISPATCH_CNT_EN
  logic [7:0] job_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      job_cnt <= '0;
    end else if (capture) begin
      job_cnt <= job_cnt + 8'd1;
    end
  end

  assign jobs_done = job_cnt;
`else
  assign jobs_done = '0;
`endif

endmodule

// File: tb/tb_cudu_dispatch.sv
// Bench for cudu_dispatch: behavioural engine model, operand/result scoreboards, directed and random jobs.
// Honours CUDU_DISPATCH_CNT_EN for the expected jobs_done value.
`timescale 1ns/1ps
module tb_cudu_dispatch;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] in_x = '0;
  logic [3:0] in_y = '0;
  logic       in_ready;
  logic       eng_start;
  logic [3:0] eng_xin;
  logic [3:0] eng_yin;
  logic       eng_idle = 1'b1;
  logic       eng_done = 1'b0;
  logic [7:0] eng_x = '0;
  logic       res_valid;
  logic [7:0] res_data;
  logic       res_ready = 1'b0;
  logic [7:0] jobs_done;

  always #5 clk = ~clk;

  cudu_dispatch #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_ready  (in_ready),
    .eng_start (eng_start),
    .eng_xin   (eng_xin),
    .eng_yin   (eng_yin),
    .eng_idle  (eng_idle),
    .eng_done  (eng_done),
    .eng_x     (eng_x),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_ready (res_ready),
    .jobs_done (jobs_done)
  );

  // ---------------- scoreboard state ----------------
  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] op_q[$];
  logic [7:0] exp_jobs = '0;

  int         idle_lat = 2;
  int         run_len  = 4;
  bit         rand_run = 1'b0;

  int         eng_st  = 0;
  int         eng_cnt = 0;
  int         eng_run = 0;
  int         eng_len = 4;
  logic [7:0] eng_ops = '0;

  int         start_cnt  = 0;
  int         start_run  = 0;
  logic       prev_start = 1'b0;
  logic [7:0] start_ops  = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Engine result function used by both the engine model and the scoreboard.
  function automatic logic [7:0] eng_fn(input logic [3:0] x, input logic [3:0] y);
    if (x == 4'd2 && y == 4'd15) return 8'h00;
    if (x == 4'd15 && y == 4'd2) return 8'h0a;
    if (x == 4'd3 && y == 4'd15) return 8'h02;
    return {x, y} ^ 8'ha5;
  endfunction

  function automatic logic [7:0] exp_cnt();
`ifdef CUDU_DISPATCH_CNT_EN
    return exp_jobs;
`else
    return 8'd0;
`endif
  endfunction

  // ---------------- engine model ----------------
  always @(negedge clk) begin
    if (!rst) begin
      eng_st   = 0;
      eng_cnt  = 0;
      eng_idle = 1'b1;
      eng_done = 1'b0;
      eng_x    = '0;
    end else begin
      case (eng_st)
        0: begin
          if (eng_start) begin
            eng_cnt++;
            if (eng_cnt >= idle_lat) begin
              eng_idle = 1'b0;
              eng_ops  = {eng_xin, eng_yin};
              if (op_q.size() == 0) check("op_unexpected", 32'(op_q.size()), 32'd1);
              else check("op_order", 32'(eng_ops), 32'(op_q.pop_front()));
              eng_run = 0;
              eng_len = rand_run ? int'($urandom_range(1, 5)) : run_len;
              eng_st  = 1;
            end
          end
        end
        1: begin
          eng_run++;
          if (eng_run >= eng_len) begin
            eng_done = 1'b1;
            eng_x    = eng_fn(eng_ops[7:4], eng_ops[3:0]);
            check("xin_stable", 32'({eng_xin, eng_yin}), 32'(eng_ops));
            eng_st   = 2;
          end
        end
        default: begin
          eng_done = 1'b0;
          eng_idle = 1'b1;
          eng_x    = '0;
          eng_cnt  = 0;
          eng_st   = 0;
        end
      endcase
    end
  end

  // ---------------- output monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      prev_start = 1'b0;
      start_run  = 0;
      exp_jobs   = '0;
    end else begin
      if (eng_start && !prev_start) begin
        start_cnt++;
        start_ops = {eng_xin, eng_yin};
        check("start_res_clear", 32'(res_valid), 32'd0);
      end
      if (eng_start) begin
        start_run++;
      end else if (prev_start) begin
        check("start_width", 32'(start_run), 32'(idle_lat));
        check("start_stable", 32'({eng_xin, eng_yin}), 32'(start_ops));
        start_run = 0;
      end
      prev_start = eng_start;
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) check("res_unexpected", 32'(exp_q.size()), 32'd1);
        else check("res_data", 32'(res_data), 32'(exp_q.pop_front()));
        exp_jobs++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_pair(input logic [3:0] x, input logic [3:0] y);
    int n = 0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_x     = x;
    in_y     = y;
    @(negedge clk);
    while (!in_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("push_accept", 32'(in_ready), 32'd1);
    if (in_ready) begin
      op_q.push_back({x, y});
      exp_q.push_back(eng_fn(x, y));
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic push_while_full(input logic [3:0] x, input logic [3:0] y);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_x     = x;
    in_y     = y;
    @(negedge clk);
    check("full_drop_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic set_res_ready(input logic v);
    @(posedge clk); #1;
    res_ready = v;
  endtask

  task automatic wait_res_valid(input int budget);
    int n = 0;
    while (!res_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("res_valid_wait", 32'(res_valid), 32'd1);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || op_q.size() != 0 || res_valid || !eng_idle) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(n < budget), 32'd1);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b0;
    exp_q.delete();
    op_q.delete();
    @(posedge clk); #2;
    rst = 1'b1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int base;
    int n;

    // Reset values
    #3 rst = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_eng_start", 32'(eng_start), 32'd0);
    check("rst_eng_xin", 32'(eng_xin), 32'd0);
    check("rst_eng_yin", 32'(eng_yin), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_data", 32'(res_data), 32'd0);
    check("rst_jobs_done", 32'(jobs_done), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Reset asserted while the engine is running a job
    idle_lat = 2;
    run_len  = 4;
    push_pair(4'd2, 4'd15);
    n = 0;
    while (eng_st != 1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("midjob_busy", 32'(eng_st), 32'd1);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check("midrst_eng_start", 32'(eng_start), 32'd0);
    check("midrst_eng_xin", 32'(eng_xin), 32'd0);
    check("midrst_eng_yin", 32'(eng_yin), 32'd0);
    check("midrst_res_valid", 32'(res_valid), 32'd0);
    check("midrst_res_data", 32'(res_data), 32'd0);
    check("midrst_jobs_done", 32'(jobs_done), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    exp_q.delete();
    op_q.delete();
    @(posedge clk); #2;
    rst = 1'b1;
    base = start_cnt;
    repeat (10) @(negedge clk);
    check("no_start_after_rst", 32'(start_cnt), 32'(base));
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Single job, result held until read
    res_ready = 1'b0;
    push_pair(4'd2, 4'd15);
    wait_res_valid(100);
    check("single_res_data", 32'(res_data), 32'h00);
    set_res_ready(1'b1);
    wait_drain(100);
    check("single_jobs", 32'(jobs_done), 32'(exp_cnt()));

    // Back-to-back jobs with the consumer always ready
    do_reset();
    push_pair(4'd15, 4'd2);
    push_pair(4'd3, 4'd15);
    wait_drain(200);
    check("b2b_jobs", 32'(jobs_done), 32'(exp_cnt()));
`ifdef CUDU_DISPATCH_CNT_EN
    check("b2b_jobs_two", 32'(jobs_done), 32'd2);
`endif

    // Fill the FIFO behind an unread result, then drain in order
    set_res_ready(1'b0);
    push_pair(4'd1, 4'd1);
    wait_res_valid(100);
    push_pair(4'd5, 4'd6);
    push_pair(4'd7, 4'd8);
    push_pair(4'd9, 4'd10);
    push_pair(4'd11, 4'd12);
    @(negedge clk);
    check("full_in_ready", 32'(in_ready), 32'd0);
    push_while_full(4'd13, 4'd14);
    check("full_queue_len", 32'(op_q.size()), 32'(DEPTH));
    set_res_ready(1'b1);
    wait_drain(400);

    // Slow engine: start must stay high while the engine remains idle
    idle_lat = 5;
    push_pair(4'd4, 4'd5);
    push_pair(4'd6, 4'd7);
    wait_drain(400);
    idle_lat = 2;

    // Many random jobs, covering counter wrap
    do_reset();
    rand_run = 1'b1;
    res_ready = 1'b1;
    for (int i = 0; i < 257; i++) begin
      push_pair(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end
    wait_drain(20000);
    check("wrap_jobs", 32'(jobs_done), 32'(exp_cnt()));
`ifdef CUDU_DISPATCH_CNT_EN
    check("wrap_jobs_one", 32'(jobs_done), 32'd1);
`else
    check("wrap_jobs_zero", 32'(jobs_done), 32'd0);
`endif
    check("final_in_ready", 32'(in_ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cudu_dispatch.md
# cudu_dispatch

Upstream operand dispatcher for the cudu FSM+datapath engine. It buffers 4-bit operand pairs from a valid/ready producer in a small FIFO and drives the engine's start/xin/yin handshake, one job at a time. It captures the engine's 8-bit x result on done and presents it on a one-deep valid/ready result port. The engine never sees an operand change or a start pulse while it is busy.

## Interface
- DEPTH, 4: operand FIFO entries; power of two, minimum 2.
- AW, 2: log2(DEPTH).

- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  producer offers an operand pair.
- in_x  in  4  operand x.
- in_y  in  4  operand y.
- in_ready  out  1  FIFO not full.
- eng_start  out  1  start request to the engine.
- eng_xin  out  4  operand x to the engine.
- eng_yin  out  4  operand y to the engine.
- eng_idle  in  1  engine is idle.
- eng_done  in  1  engine result is valid.
- eng_x  in  8  engine result.
- res_valid  out  1  result slot is full.
- res_data  out  8  captured result.
- res_ready  in  1  consumer takes the result.
- jobs_done  out  8  completed-job counter; see Configuration.

## Operation
- FIFO: a push happens when in_valid && in_ready. in_ready = !full, with no pass-through when full; a pop in the same cycle does not admit a push into a full FIFO. Pointers are AW+1 bits and wrap modulo DEPTH.
- FSM states: IDLE, START, WAIT.
- IDLE -> START when the FIFO is non-empty, res_valid==0, and eng_idle==1.
  - On that edge the head entry is popped into eng_xin/eng_yin.
  - eng_start is registered to 1.
- START: eng_start is held at 1.
  - START -> WAIT on the first edge where eng_idle==0 (the engine has accepted the job); eng_start is cleared on that edge.
- WAIT: eng_start==0.
  - WAIT -> IDLE on the first edge where eng_done==1; res_data<=eng_x and res_valid<=1 on that edge.
- eng_xin/eng_yin stay stable from the pop until the next pop.
- Result slot: res_valid is cleared on an edge where res_valid && res_ready.
  - No new job is issued while res_valid==1, so a capture never overwrites an unread result.
- eng_done is ignored in IDLE and START.
- A push to an empty FIFO and a pop never coincide, because a pop requires a non-empty FIFO at the sampling edge.

## Timing
- Reset (rst==0, asynchronous): state=IDLE, FIFO empty, in_ready=1, eng_start=0, eng_xin=0, eng_yin=0, res_valid=0, res_data=0, jobs_done=0.
- Reset asserted mid-job clears everything, including a captured result and queued entries. eng_start drops immediately.
- Latency with an idle engine and an empty FIFO:
  - push at edge 0;
  - pop and eng_start=1 at edge 1;
  - eng_start stays high until the edge after eng_idle falls.
- res_valid rises on the edge where eng_done is sampled high.
- The earliest next pop is one edge after the result is consumed: edge R clears res_valid, edge R+1 pops.
- Throughput: one job per engine run plus at least 2 cycles.

## Configuration
- CUDU_DISPATCH_CNT_EN defined:
  - jobs_done increments by 1 on every result capture (WAIT->IDLE) and wraps 255->0.
- Not defined:
  - jobs_done is tied to 0 and no counter flops are synthesized.

## Test plan
- Reset mid-job: issue (2,15), assert rst=0 during WAIT -> all outputs return to reset values asynchronously; after release, in_ready=1 and no eng_start occurs without a new push.
- Single job: push (2,15) with a model engine (idle falls 1 cycle after start, done 4 cycles later with eng_x=0x00) -> eng_start high for exactly 2 cycles, eng_xin=2 and eng_yin=15 stable throughout, res_valid=1 with res_data=0x00.
- Back-to-back: push (15,2) then (3,15), model results 0x0a and 0x02, res_ready held 1 -> two results in order 0x0a then 0x02; the second eng_start rises only after the first res_valid clears; with the macro defined, jobs_done=2.
- Full FIFO: hold res_ready=0 with engine results pending, push DEPTH+2 pairs -> in_ready=0 after the FIFO fills; a push attempted while full is dropped; entries drain in FIFO order once res_ready=1.
- Slow engine: keep eng_idle=1 for 5 cycles after eng_start -> eng_start stays high for those 5 cycles, with no second pop and no state change.
- Counter wrap: with CUDU_DISPATCH_CNT_EN defined, run 257 jobs -> jobs_done=1; without the macro, jobs_done stays 0 throughout.
